led_status_array: RTL and testbench
===================================

LED_STATUS_ARRAY -- requirements
Module: led_status_array

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter PRESC_W, default 24, prescaler width; one tick every 2^PRESC_W clocks.
REQ-003 Parameter PWM_W, default 6, brightness resolution in bits.
REQ-004 Parameter HOLD_TICKS, default 2, activity-flash length in ticks (1..255).
REQ-005 Port clk  input  1  sole clock; all state SHALL be on posedge clk.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port mode  input  2*NUM_CH  per-channel mode, channel n at bits [2n+1:2n]; 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
REQ-008 Port activity  input  NUM_CH  per-channel activity strobe, synchronous to clk.
REQ-009 Port led  output  NUM_CH  registered LED drive, 1 = lit.

Function
REQ-010 Prescaler pre_cnt (PRESC_W bits) SHALL increment every clock, wrapping; tick SHALL be 1 for exactly the cycle pre_cnt is all-ones.
REQ-011 Shared phase counter ph (PWM_W+1 bits) SHALL increment on tick, wrapping from all-ones to 0.
REQ-012 Breathe level SHALL be ph[PWM_W-1:0] when ph[PWM_W]=1, else bitwise NOT of ph[PWM_W-1:0] (triangle ramp).
REQ-013 Per channel, accumulator acc (PWM_W+1 bits) SHALL update acc <= {0,acc[PWM_W-1:0]} + level each clock while mode=BREATHE; sigma-delta bit = acc[PWM_W].
REQ-014 acc SHALL be held at 0 whenever mode != BREATHE; entering BREATHE starts from acc=0.
REQ-015 Base value: OFF -> 0; ON -> 1; BLINK -> ph[PWM_W]; BREATHE -> acc[PWM_W] (value after the current update).
REQ-016 Rising edge of activity[n] (current 1, previous-cycle 1-clock-delayed copy 0) SHALL load flash counter fc[n] with HOLD_TICKS.
REQ-017 fc[n] SHALL decrement by 1 on tick while nonzero; saturates at 0.
REQ-018 Simultaneous edge and tick: load SHALL win (fc = HOLD_TICKS, no decrement).
REQ-019 Edge while fc nonzero SHALL retrigger (reload); a held-high activity SHALL cause only one load.
REQ-020 led[n] SHALL register base XOR (fc[n] != 0), i.e. flash inverts the mode output; latency one clock from mode/fc/acc change.
REQ-021 mode changes SHALL take effect on the next clock edge; no glitch beyond the registered output.
REQ-022 Channels SHALL be fully independent except shared pre_cnt, tick, ph.

Reset
REQ-023 rst_n low SHALL asynchronously clear pre_cnt, ph, every acc, fc, activity-delay register and led to 0.
REQ-024 Release of rst_n mid-operation SHALL restart from the all-zero state; first tick occurs 2^PRESC_W clocks after release.

Structure
REQ-025 Package led_status_pkg SHALL hold mode constants MODE_OFF/ON/BLINK/BREATHE and the 2-bit mode type.
REQ-026 Sub-module led_status_channel SHALL contain acc, fc, edge detect and led register; instantiated NUM_CH times by generate; prescaler, ph and level stay in top.

Verification (PRESC_W=4, PWM_W=3, HOLD_TICKS=2, NUM_CH=4 unless stated)
REQ-027 Reset: rst_n low mid-run with all modes ON -> led=0000 same cycle, pre_cnt/ph=0; first tick 16 clocks after release.
REQ-028 Static modes: mode={BLINK,ON,OFF,... } per channel -> OFF stays 0, ON lit one clock after setting, BLINK toggles every 8 ticks (128 clocks).
REQ-029 Breathe: ch0 BREATHE from reset, ph=0 (level 7) -> 14+/-1 ones in the first 16 clocks; at ph=8 (level 0) -> 0 ones in that window.
REQ-030 Activity: ch1 ON, single-cycle activity pulse -> led[1]=0 from next clock until fc expires after 2 ticks (16-32 clocks), then 1.
REQ-031 Edge coincident with tick and retrigger: pulse on tick cycle -> fc=2 not 1; second pulse while fc=1 -> fc reloads to 2; activity held high 100 clocks -> one flash only.
REQ-032 Mode switch BREATHE->OFF->BREATHE -> acc reads 0 on re-entry; other channels unaffected.

Source files
------------

// File: rtl/led_status_pkg.sv
// led_status_pkg: mode encoding shared by the LED status array and its channels
package led_status_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

endpackage

// File: rtl/led_status_channel.sv
// led_status_channel: one LED with sigma-delta breathing, activity flash and registered drive
module led_status_channel
   import led_status_pkg::*;
#(
   parameter int PWM_W      = 6,
   parameter int HOLD_TICKS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  mode_t            mode,
   input  logic             activity,
   input  logic [PWM_W-1:0] level,
   input  logic             blink,
   output logic             led
);

   // The accumulator carry is consumed in the same cycle it is produced, so only the low bits persist.
   logic [PWM_W-1:0] acc_lo;
   logic [PWM_W:0]   acc_nxt;
   logic [7:0]       fc;
   logic [7:0]       fc_nxt;
   logic             act_d;
   logic             rise;
   logic             base;

   // Next accumulator, edge detect, flash counter and mode-selected base value
   always_comb begin
      acc_nxt = (mode == MODE_BREATHE) ? {1'b0, acc_lo} + {1'b0, level} : '0;
      rise    = activity & ~act_d;
      fc_nxt  = rise ? 8'(HOLD_TICKS) : (tick && fc != 8'd0) ? fc - 8'd1 : fc;
      base    = (mode == MODE_OFF)   ? 1'b0 :
                (mode == MODE_ON)    ? 1'b1 :
                (mode == MODE_BLINK) ? blink : acc_nxt[PWM_W];
   end

   // Channel state; a running flash inverts whatever the mode would show
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_lo <= '0;
         fc     <= '0;
         act_d  <= 1'b0;
         led    <= 1'b0;
      end else begin
         acc_lo <= acc_nxt[PWM_W-1:0];
         fc     <= fc_nxt;
         act_d  <= activity;
         led    <= base ^ (fc != 8'd0);
      end
   end

endmodule

// File: rtl/led_status_array.sv
// led_status_array: shared prescaler/phase timebase driving NUM_CH independent LED channels
module led_status_array
   import led_status_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int PRESC_W    = 24,
   parameter int PWM_W      = 6,
   parameter int HOLD_TICKS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2*NUM_CH-1:0] mode,
   input  logic [NUM_CH-1:0]   activity,
   output logic [NUM_CH-1:0]   led
);

   logic [PRESC_W-1:0] pre_cnt;
   logic [PWM_W:0]     ph;
   logic               tick;
   logic [PWM_W-1:0]   level;

   // Tick marks the last prescaler count; level ramps up in the upper half of ph and down in the lower half
   always_comb begin
      tick  = &pre_cnt;
      level = ph[PWM_W] ? ph[PWM_W-1:0] : ~ph[PWM_W-1:0];
   end

   // Free-running prescaler and tick-driven phase counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         ph      <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         if (tick) ph <= ph + 1'b1;
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      led_status_channel #(
         .PWM_W      (PWM_W),
         .HOLD_TICKS (HOLD_TICKS)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick     (tick),
         .mode     (mode_t'(mode[2*n +: 2])),
         .activity (activity[n]),
         .level    (level),
         .blink    (ph[PWM_W]),
         .led      (led[n])
      );
   end

endmodule

// File: tb/tb_led_status_array.sv
// tb_led_status_array: directed and random stimulus against a cycle-level reference model
module tb_led_status_array;

   localparam int N = 4;
   localparam int P = 4;
   localparam int W = 3;
   localparam int H = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [2*N-1:0] mode = '0;
   logic [N-1:0]   activity = '0;
   logic [N-1:0]   led;

   int checks = 0;
   int errors = 0;

   int           pcnt, ph, used_ph;
   int           accl [N];
   int           fc [N];
   bit           prev [N];
   logic [N-1:0] lm;

   led_status_array #(.NUM_CH(N), .PRESC_W(P), .PWM_W(W), .HOLD_TICKS(H)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .activity (activity),
      .led      (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pcnt = 0;
      ph   = 0;
      lm   = '0;
      for (int c = 0; c < N; c++) begin
         accl[c] = 0;
         fc[c]   = 0;
         prev[c] = 1'b0;
      end
   endtask

   task automatic model_step();
      int period = 1 << P;
      int half   = 1 << W;
      bit tk     = (pcnt == period - 1);
      int level  = (ph >= half) ? ph - half : (half - 1) - ph;
      used_ph = ph;
      for (int c = 0; c < N; c++) begin
         int m = int'(mode[2*c +: 2]);
         bit b;
         if (m == 3) begin
            int s = accl[c] + level;
            b = (s >= half);
            accl[c] = s % half;
         end else begin
            accl[c] = 0;
            b = (m == 1) || (m == 2 && ph >= half);
         end
         lm[c] = b ^ (fc[c] != 0);
         if (activity[c] && !prev[c]) fc[c] = H;
         else if (tk && fc[c] > 0) fc[c] = fc[c] - 1;
         prev[c] = activity[c];
      end
      pcnt = (pcnt + 1) % period;
      if (tk) ph = (ph + 1) % (2 * half);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("led", 32'(led), 32'(lm));
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_async_led", 32'(led), 32'd0);
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int ones0, ones8, t0, len, falls;
      logic pl;
      do_reset(2);

      mode = 8'b00_00_00_11;
      ones0 = 0;
      ones8 = 0;
      repeat (160) begin
         cyc();
         if (used_ph == 0) ones0 += int'(led[0]);
         if (used_ph == 8) ones8 += int'(led[0]);
      end
      chk("breathe_ph0_in_13_15", 32'(ones0 >= 13 && ones0 <= 15), 32'd1);
      chk("breathe_ph8_zero", 32'(ones8), 32'd0);

      mode = 8'b11_10_01_00;
      cyc();
      chk("on_latency", 32'(led[1]), 32'd1);
      t0 = -1;
      pl = led[2];
      for (int k = 0; k < 400; k++) begin
         cyc();
         chk("off_stays_dark", 32'(led[0]), 32'd0);
         if (led[2] !== pl) begin
            if (t0 >= 0) chk("blink_period", 32'(k - t0), 32'd128);
            t0 = k;
         end
         pl = led[2];
      end

      mode = 8'b00_00_01_00;
      repeat (40) cyc();
      while (pcnt != 15) cyc();
      activity = 4'b0010;
      cyc();
      activity = '0;
      len = 0;
      repeat (40) begin
         cyc();
         if (!led[1]) len++;
      end
      chk("flash_len_edge_on_tick", 32'(len), 32'd32);

      while (pcnt != 15) cyc();
      activity = 4'b0010;
      cyc();
      activity = '0;
      repeat (20) cyc();
      activity = 4'b0010;
      cyc();
      activity = '0;
      len = 0;
      repeat (50) begin
         cyc();
         if (!led[1]) len++;
      end
      chk("retrigger_len", 32'(len), 32'd27);

      activity = 4'b0010;
      falls = 0;
      pl = led[1];
      for (int k = 0; k < 150; k++) begin
         if (k == 100) activity = '0;
         cyc();
         if (pl && !led[1]) falls++;
         pl = led[1];
      end
      chk("held_high_one_flash", 32'(falls), 32'd1);

      mode = 8'b11_10_01_11;
      repeat (37) cyc();
      mode[1:0] = 2'd0;
      repeat (5) cyc();
      mode[1:0] = 2'd3;
      repeat (60) cyc();

      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(39) == 0) begin
            int c = int'($urandom_range(N - 1));
            mode[2*c +: 2] = 2'($urandom_range(3));
         end
         for (int c = 0; c < N; c++)
            activity[c] = ($urandom_range(29) == 0) ? ~activity[c] : activity[c];
         cyc();
      end

      activity = '0;
      mode = 8'h55;
      repeat (37) cyc();
      do_reset(3);
      activity = 4'b0010;
      cyc();
      chk("post_reset_all_on", 32'(led), 32'hF);
      activity = '0;
      len = 0;
      repeat (40) begin
         cyc();
         if (!led[1]) len++;
      end
      chk("post_reset_first_tick", 32'(len), 32'd31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
